command_arbiter: RTL

- Round-robin arbiter that shares one command_fifo write port among NUM_REQ command producers (game logic, track generator, sprite/renderer setup).
- Producers present commands with valid/ready handshakes. A producer may hold the grant for a multi-command burst, bounded by MAX_BURST, so that related commands land contiguously in the FIFO.
- Sits directly in front of command_fifo: drives its write and command_in, and observes its full.

---
 rtl/command_pkg.sv | 8 +
 rtl/command_arbiter_picker.sv | 26 ++
 rtl/command_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/command_pkg.sv
// Types shared by the command arbiter and every command_fifo user.
package command_pkg;
    localparam int CMD_WIDTH = 16;

    typedef logic [CMD_WIDTH-1:0] cmd_t;

    typedef enum logic {IDLE, BURST} arb_state_t;
endpackage

// File: rtl/command_arbiter_picker.sv
// Rotating-priority picker: first asserted request at or after i_ptr, wrapping modulo N.
module rr_priority_picker #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic          o_found,
    output logic [PW-1:0] o_idx
);
    logic [PW-1:0] w_cand;

    // Scan farthest-to-nearest so the nearest candidate to i_ptr is the last assignment.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = PW'((int'(i_ptr) + k) % N);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end
endmodule

// File: rtl/command_arbiter.sv
// Round-robin burst arbiter feeding one command_fifo write port.
// Define ARB_PRIO0_EN to let requester 0 win every IDLE arbitration it is valid for.
module command_arbiter
    import command_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int WIDTH     = CMD_WIDTH,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_command,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     fifo_write,
    output logic [WIDTH-1:0]         fifo_command,
    input  logic                     fifo_full,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t    r_state, w_state_nxt;
    logic [PW-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [PW-1:0] r_grant_idx, w_grant_idx_nxt;
    logic [CW-1:0] r_beat_cnt, w_beat_cnt_nxt;
    logic [PW-1:0] w_sel, w_sel_inc, w_pick_idx;
    logic          w_found, w_pick_found, w_xfer, w_end;

    rr_priority_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_found = 1'b0;
        w_sel   = r_grant_idx;
        if (r_state == BURST) begin
            w_found = 1'b1;
        end else begin
`ifdef ARB_PRIO0_EN
            if (req_valid[0]) begin
                w_found = 1'b1;
                w_sel   = '0;
            end else begin
                w_found = w_pick_found;
                w_sel   = w_pick_idx;
            end
`else
            w_found = w_pick_found;
            w_sel   = w_pick_idx;
`endif
        end
        if (rst) w_found = 1'b0;

        w_sel_inc = (w_sel == PW'(NUM_REQ - 1)) ? '0 : w_sel + PW'(1);

        grant     = '0;
        req_ready = '0;
        if (w_found) begin
            grant[w_sel]     = 1'b1;
            req_ready[w_sel] = !fifo_full;
        end

        w_xfer       = w_found & req_valid[w_sel] & !fifo_full;
        fifo_write   = w_xfer;
        fifo_command = req_command[w_sel*WIDTH +: WIDTH];
        busy         = (r_state == BURST) & !rst;
        // In IDLE the count is zero, so MAX_BURST=1 ends every grant on its first beat.
        w_end        = w_xfer & (req_last[w_sel] |
                       (({1'b0, r_beat_cnt} + (CW+1)'(1)) == (CW+1)'(MAX_BURST)));
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_idx_nxt = r_grant_idx;
        w_beat_cnt_nxt  = r_beat_cnt;
        if (w_xfer) begin
            if (w_end) begin
                w_state_nxt    = IDLE;
                w_beat_cnt_nxt = '0;
                w_rr_ptr_nxt   = w_sel_inc;
            end else if (r_state == IDLE) begin
                w_state_nxt     = BURST;
                w_grant_idx_nxt = w_sel;
                w_beat_cnt_nxt  = CW'(1);
            end else begin
                w_beat_cnt_nxt  = r_beat_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_beat_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
        end
    end
endmodule
